mips_multicycle_control: RTL
============================

Name: mips_multicycle_control

Overview:
- Multicycle control unit for the MIPS_FPU core. It replaces single-cycle combinational decode with a registered FSM: FETCH, DECODE, EXEC, MEM, WB, WAIT_MUL, WAIT_FPU.
- Sequences the existing datapath muxes (muxA, muxB, muxWD3, muxPC, register-write address select) across cycles.
- Adds a multi-cycle integer multiply and a start/done handshake to the FPU.

Parameters:
- MULT_CYCLES, default 4: cycles the multiplier needs. Legal range 1..255.
- FPU_TIMEOUT, default 16: maximum cycles to wait for fpu_done. Legal range 1..255.
- ENABLE_MULT, default 1: if 0, funct 0x18 decodes as illegal.
- ENABLE_FPU, default 1: if 0, opcode 0x11 decodes as illegal.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- instr_valid  in  1  instruction memory output valid this cycle.
- opcode  in  6  instr[31:26].
- functcode  in  6  instr[5:0].
- zero  in  1  ALU zero flag.
- fpu_done  in  1  FPU result ready.
- pcWrite  out  1  PC register load enable.
- irWrite  out  1  instruction-register load enable.
- regWrite  out  1  integer register-file write enable.
- fpRegWrite  out  1  FP register-file write enable.
- dm_we  out  1  data-memory write enable.
- muxA_en  out  1  ALU A-operand select.
- muxWD3_en  out  1  writeback select: 1 = ALU/multiplier, 0 = memory.
- multiplyEn  out  1  multiplier enable / result select.
- fpu_start  out  1  one-cycle FPU start pulse.
- muxB_en  out  2  ALU B select: 0 = immediate, 1 = register, 2 = constant for link.
- regWriteAddSelect  out  2  write address: 0 = rt, 1 = r31, 2 = rd.
- muxPC  out  2  next PC: 0 = PC+4, 1 = jump target, 2 = register, 3 = branch target.
- ALUop  out  3  0 = add, 1 = sub, 2 = xor, 3 = slt.
- fpuOp  out  2  0 = add.s, 1 = sub.s, 2 = mul.s.
- state_out  out  3  current state encoding, for debug.
- illegal  out  1  one-cycle pulse on an undecodable instruction or an FPU timeout.

Behaviour:
- Clocking and reset: single clock domain, synchronous active-high reset.
  - On reset: state = FETCH, latched opcode/funct = 0, counter = 0.
  - While reset is high, every output is 0.
- Output timing:
  - Outputs are combinational decodes of the registered state, the latched opcode/funct, zero and fpu_done.
  - Any output not listed for a state is 0.
- FETCH (state 0):
  - If instr_valid: irWrite = 1, pcWrite = 1, muxPC = 0; latch opcode/funct; go to DECODE.
  - Otherwise hold in FETCH with all outputs 0.
- DECODE (state 1, one cycle):
  - J: pcWrite = 1, muxPC = 1; go to FETCH.
  - JAL: pcWrite = 1, muxPC = 1, regWrite = 1, regWriteAddSelect = 1, muxA_en = 1, muxB_en = 2, muxWD3_en = 1, ALUop = 0; go to FETCH.
  - JR (R-type, funct 0x08): pcWrite = 1, muxPC = 2; go to FETCH.
  - Illegal opcode/funct: illegal = 1; go to FETCH (no state change).
  - Everything else: go to EXEC.
- EXEC (state 2):
  - R-type ADD/SUB/SLT: muxB_en = 1, ALUop = 0/1/3; go to WB.
  - ADDI, XORI: muxB_en = 0, ALUop = 0 or 2; go to WB.
  - LW: ALUop = 0, muxB_en = 0; go to MEM.
  - SW: ALUop = 0, muxB_en = 0, dm_we = 1; go to FETCH.
  - BEQ/BNE: ALUop = 1, muxB_en = 1. If (zero for BEQ) or (!zero for BNE): pcWrite = 1, muxPC = 3. Go to FETCH.
  - MULT (funct 0x18): multiplyEn = 1, muxB_en = 1; counter ← MULT_CYCLES−1; go to WAIT_MUL, or to WB if MULT_CYCLES = 1.
  - COP1 (opcode 0x11): fpu_start = 1, fpuOp = funct[1:0]; counter ← 0; go to WAIT_FPU.
  - COP1 funct above 2 is illegal and is caught in DECODE.
- MEM (state 3): ALUop = 0, muxB_en = 0 (address held); go to WB.
- WB (state 4): regWrite = 1; go to FETCH.
  - Loads: muxWD3_en = 0, regWriteAddSelect = 0.
  - I-type: muxWD3_en = 1, regWriteAddSelect = 0.
  - R-type and MULT: muxWD3_en = 1, regWriteAddSelect = 2.
  - MULT additionally holds multiplyEn = 1.
- WAIT_MUL (state 5): multiplyEn = 1, muxB_en = 1; counter decrements each cycle; go to WB when counter = 1.
- WAIT_FPU (state 6): fpuOp held, counter increments.
  - If fpu_done: fpRegWrite = 1 in the same cycle; go to FETCH.
  - Else if counter = FPU_TIMEOUT−1: illegal = 1; go to FETCH with no write.
  - fpu_done and timeout in the same cycle: fpu_done wins.
- Latency in cycles, instr_valid always high:
  - J/JAL/JR: 2
  - SW, BEQ, BNE: 3
  - ADD, SUB, SLT, ADDI, XORI: 4
  - LW: 5
  - MULT: 3 + MULT_CYCLES
- Boundary rules:
  - Reset asserted in any state, including WAIT_MUL or WAIT_FPU, returns to FETCH on the next edge. No write enable may fire on that edge.
  - instr_valid is ignored in every state other than FETCH.
  - Counter width is 8 bits and must never wrap.

Test Plan:
- Reset mid-WAIT_MUL (MULT_CYCLES = 4, reset held in cycle 2 of the wait) → state_out = 0 next cycle; regWrite and multiplyEn stay 0 throughout.
- ADD (op 0, funct 0x20) then LW (op 0x23), instr_valid held high:
  - ADD: regWrite pulses in cycle 4 with regWriteAddSelect = 2, muxWD3_en = 1.
  - LW: regWrite pulses in cycle 5 with muxWD3_en = 0, regWriteAddSelect = 0.
- BEQ with zero = 1 → pcWrite = 1, muxPC = 3 in EXEC. BNE with zero = 1 → muxPC stays 0 and pcWrite = 0 in EXEC.
- JAL → in DECODE: pcWrite = 1, muxPC = 1, regWrite = 1, regWriteAddSelect = 1, muxB_en = 2; then FETCH.
- MULT with MULT_CYCLES = 4 → multiplyEn high for 5 consecutive cycles, regWrite in the last of them; total latency 7. Also check MULT_CYCLES = 1 gives latency 4.
- COP1 funct 2:
  - fpu_done raised 3 cycles after fpu_start → fpRegWrite = 1 coincident with fpu_done, fpuOp = 2.
  - Withhold fpu_done with FPU_TIMEOUT = 16 → illegal pulses once, 16 cycles after entering WAIT_FPU.
  - Opcode 0x3f → illegal pulse in DECODE, no write enables.

Source files
------------

// File: rtl/mips_multicycle_control.sv
// ---------------------------------------------------------------------------
// mips_multicycle_control
//
// Multicycle control unit for the MIPS_FPU core. A registered FSM
// (FETCH, DECODE, EXEC, MEM, WB, WAIT_MUL, WAIT_FPU) sequences the datapath
// muxes across cycles, runs a fixed-latency integer multiply and performs a
// start/done handshake with the FPU, with a timeout.
//
// Ports:
//   clk, reset           rising-edge clock, synchronous active-high reset
//   instr_valid          instruction memory output valid (used in FETCH only)
//   opcode, functcode    instr[31:26], instr[5:0]
//   zero                 ALU zero flag (branch resolution in EXEC)
//   fpu_done             FPU result ready (WAIT_FPU only)
//   pcWrite, irWrite     PC / instruction-register load enables
//   regWrite, fpRegWrite integer / FP register-file write enables
//   dm_we                data-memory write enable
//   muxA_en, muxB_en     ALU operand selects (B: 0 imm, 1 reg, 2 link const)
//   muxWD3_en            writeback select: 1 ALU/multiplier, 0 memory
//   regWriteAddSelect    write address: 0 rt, 1 r31, 2 rd
//   muxPC                next PC: 0 PC+4, 1 jump, 2 register, 3 branch
//   multiplyEn           multiplier enable / result select
//   fpu_start, fpuOp     one-cycle FPU start pulse and FPU operation
//   ALUop                0 add, 1 sub, 2 xor, 3 slt
//   state_out            current state encoding (debug)
//   illegal              one-cycle pulse: undecodable instruction / FPU timeout
// All outputs are forced to 0 while reset is high.
// ---------------------------------------------------------------------------
module mips_multicycle_control #(
  parameter int MULT_CYCLES = 4,
  parameter int FPU_TIMEOUT = 16,
  parameter int ENABLE_MULT = 1,
  parameter int ENABLE_FPU  = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       instr_valid,
  input  logic [5:0] opcode,
  input  logic [5:0] functcode,
  input  logic       zero,
  input  logic       fpu_done,
  output logic       pcWrite,
  output logic       irWrite,
  output logic       regWrite,
  output logic       fpRegWrite,
  output logic       dm_we,
  output logic       muxA_en,
  output logic       muxWD3_en,
  output logic       multiplyEn,
  output logic       fpu_start,
  output logic [1:0] muxB_en,
  output logic [1:0] regWriteAddSelect,
  output logic [1:0] muxPC,
  output logic [2:0] ALUop,
  output logic [1:0] fpuOp,
  output logic [2:0] state_out,
  output logic       illegal
);

  typedef enum logic [2:0] {
    S_FETCH    = 3'd0,
    S_DECODE   = 3'd1,
    S_EXEC     = 3'd2,
    S_MEM      = 3'd3,
    S_WB       = 3'd4,
    S_WAIT_MUL = 3'd5,
    S_WAIT_FPU = 3'd6
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       ir_write;
    logic       reg_write;
    logic       fp_reg_write;
    logic       dm_we;
    logic       mux_a;
    logic       mux_wd3;
    logic       mul_en;
    logic       fpu_start;
    logic [1:0] mux_b;
    logic [1:0] wr_sel;
    logic [1:0] mux_pc;
    logic [2:0] alu_op;
    logic [1:0] fpu_op;
    logic       illegal;
  } ctrl_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_XORI  = 6'h0e;
  localparam logic [5:0] OP_COP1  = 6'h11;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_SLT   = 6'h2a;

  // Counter preload for the multiply wait and the last legal FPU wait count.
  localparam logic [7:0] MUL_LOAD = 8'(MULT_CYCLES - 1);
  localparam logic [7:0] FPU_LAST = 8'(FPU_TIMEOUT - 1);
  localparam logic       MUL_ON   = (ENABLE_MULT != 0);
  localparam logic       FPU_ON   = (ENABLE_FPU != 0);

  state_t     state, state_nxt;
  logic [5:0] op_q, fn_q;
  logic [7:0] cnt, cnt_nxt;
  ctrl_t      c;

  // Instruction classes, decoded from the latched opcode/funct.
  logic is_r, is_add, is_sub, is_slt, is_jr, is_mult;
  logic is_j, is_jal, is_beq, is_bne, is_addi, is_xori, is_lw, is_sw, is_cop1;
  logic legal;

  always_comb begin
    is_r    = (op_q == OP_RTYPE);
    is_add  = is_r && (fn_q == FN_ADD);
    is_sub  = is_r && (fn_q == FN_SUB);
    is_slt  = is_r && (fn_q == FN_SLT);
    is_jr   = is_r && (fn_q == FN_JR);
    is_mult = is_r && (fn_q == FN_MULT) && MUL_ON;
    is_j    = (op_q == OP_J);
    is_jal  = (op_q == OP_JAL);
    is_beq  = (op_q == OP_BEQ);
    is_bne  = (op_q == OP_BNE);
    is_addi = (op_q == OP_ADDI);
    is_xori = (op_q == OP_XORI);
    is_lw   = (op_q == OP_LW);
    is_sw   = (op_q == OP_SW);
    // COP1 funct 0..2 only (add.s, sub.s, mul.s).
    is_cop1 = (op_q == OP_COP1) && FPU_ON && (fn_q <= 6'd2);
    legal   = is_add | is_sub | is_slt | is_jr | is_mult | is_j | is_jal |
              is_beq | is_bne | is_addi | is_xori | is_lw | is_sw | is_cop1;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values; blocking here would create ordering races.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_FETCH;
      op_q  <= '0;
      fn_q  <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (state == S_FETCH && instr_valid) begin
        op_q <= opcode;
        fn_q <= functcode;
      end
    end
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave a value unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    c         = '0;

    unique case (state)
      S_FETCH: begin
        if (instr_valid) begin
          c.ir_write = 1'b1;
          c.pc_write = 1'b1;
          state_nxt  = S_DECODE;
        end
      end

      S_DECODE: begin
        state_nxt = S_FETCH;
        if (!legal) begin
          c.illegal = 1'b1;
        end else if (is_j) begin
          c.pc_write = 1'b1;
          c.mux_pc   = 2'd1;
        end else if (is_jal) begin
          // Link: PC+8 is formed by the ALU (A = PC, B = constant) into r31.
          c.pc_write  = 1'b1;
          c.mux_pc    = 2'd1;
          c.reg_write = 1'b1;
          c.wr_sel    = 2'd1;
          c.mux_a     = 1'b1;
          c.mux_b     = 2'd2;
          c.mux_wd3   = 1'b1;
        end else if (is_jr) begin
          c.pc_write = 1'b1;
          c.mux_pc   = 2'd2;
        end else begin
          state_nxt = S_EXEC;
        end
      end

      S_EXEC: begin
        state_nxt = S_FETCH;
        if (is_add || is_sub || is_slt) begin
          c.mux_b   = 2'd1;
          c.alu_op  = is_sub ? 3'd1 : (is_slt ? 3'd3 : 3'd0);
          state_nxt = S_WB;
        end else if (is_addi || is_xori) begin
          c.alu_op  = is_xori ? 3'd2 : 3'd0;
          state_nxt = S_WB;
        end else if (is_lw) begin
          state_nxt = S_MEM;
        end else if (is_sw) begin
          c.dm_we = 1'b1;
        end else if (is_beq || is_bne) begin
          c.alu_op = 3'd1;
          c.mux_b  = 2'd1;
          if ((is_beq && zero) || (is_bne && !zero)) begin
            c.pc_write = 1'b1;
            c.mux_pc   = 2'd3;
          end
        end else if (is_mult) begin
          c.mul_en  = 1'b1;
          c.mux_b   = 2'd1;
          cnt_nxt   = MUL_LOAD;
          state_nxt = (MUL_LOAD == 8'd0) ? S_WB : S_WAIT_MUL;
        end else if (is_cop1) begin
          c.fpu_start = 1'b1;
          c.fpu_op    = fn_q[1:0];
          cnt_nxt     = '0;
          state_nxt   = S_WAIT_FPU;
        end
      end

      S_MEM: begin
        // ALU keeps computing the load address while memory responds.
        state_nxt = S_WB;
      end

      S_WB: begin
        state_nxt   = S_FETCH;
        c.reg_write = 1'b1;
        c.mul_en    = is_mult;
        if (is_lw) begin
          c.mux_wd3 = 1'b0;
          c.wr_sel  = 2'd0;
        end else if (is_addi || is_xori) begin
          c.mux_wd3 = 1'b1;
          c.wr_sel  = 2'd0;
        end else begin
          c.mux_wd3 = 1'b1;
          c.wr_sel  = 2'd2;
        end
      end

      S_WAIT_MUL: begin
        c.mul_en = 1'b1;
        c.mux_b  = 2'd1;
        // Saturating decrement: the counter can never wrap below zero.
        if (cnt != 8'd0) cnt_nxt = cnt - 8'd1;
        if (cnt <= 8'd1) state_nxt = S_WB;
      end

      S_WAIT_FPU: begin
        c.fpu_op = fn_q[1:0];
        if (fpu_done) begin
          c.fp_reg_write = 1'b1;
          state_nxt      = S_FETCH;
        end else if (cnt >= FPU_LAST) begin
          c.illegal = 1'b1;
          state_nxt = S_FETCH;
        end else begin
          // Only increments while below FPU_LAST, so it cannot wrap.
          cnt_nxt = cnt + 8'd1;
        end
      end

      default: state_nxt = S_FETCH;
    endcase

    // Nothing may be enabled on the edge that takes reset.
    if (reset) c = '0;
  end

  assign pcWrite           = c.pc_write;
  assign irWrite           = c.ir_write;
  assign regWrite          = c.reg_write;
  assign fpRegWrite        = c.fp_reg_write;
  assign dm_we             = c.dm_we;
  assign muxA_en           = c.mux_a;
  assign muxWD3_en         = c.mux_wd3;
  assign multiplyEn        = c.mul_en;
  assign fpu_start         = c.fpu_start;
  assign muxB_en           = c.mux_b;
  assign regWriteAddSelect = c.wr_sel;
  assign muxPC             = c.mux_pc;
  assign ALUop             = c.alu_op;
  assign fpuOp             = c.fpu_op;
  assign illegal           = c.illegal;
  assign state_out         = reset ? 3'd0 : state;

endmodule
